reg_master: RTL and testbench

- Register-bus initiator; drives the single-cycle addr/wdata/we/re/rdata interface used by the SoC peripherals (gpio and others).
- Accepts commands from a controller through a valid/ready request port and buffers them in a command FIFO.
- Executes each command as a bus WRITE, READ, or read-modify-write SET/CLEAR.
- Returns one response per command on a valid/ready response port.

---
 rtl/reg_master.sv | 211 +++++++++++++++++++++
 tb/tb_reg_master.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_master.sv
// reg_master: register-bus initiator.
//
// Accepts WRITE / READ / SET / CLEAR commands on a valid/ready request port,
// buffers them in a small command FIFO and executes each one on the
// single-cycle addr/wdata/we/re/rdata peripheral bus. SET and CLEAR are
// read-modify-write sequences. One response per command is returned on a
// valid/ready response port.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o command handshake
//   req_op_i                00 WRITE, 01 READ, 10 SET, 11 CLEAR
//   req_addr_i, req_data_i  target address, write data or bit mask
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_data_o              read data / pre-modify value / 0 for WRITE
//   bus_addr_o, bus_wdata_o, bus_we_o, bus_re_o, bus_rdata_i  peripheral bus
//   busy_o                  FSM not idle or commands pending
module reg_master #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic              bus_we_o,
    output logic              bus_re_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              busy_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;

    typedef struct packed {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StModify,
        StResp
    } state_e;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    cmd_t             req_cmd;

    assign req_cmd     = '{op: req_op_i, addr: req_addr_i, data: req_data_i};
    assign fifo_empty  = (count_q == '0);
    // Ready looks only at the count: a same-cycle pop never frees a full FIFO.
    assign req_ready_o = (count_q != CNT_W'(DEPTH));
    assign push        = req_valid_i && req_ready_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= req_cmd;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    cmd_t             cmd_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] modify_data;
    logic              cmd_is_rmw;

    assign cmd_is_rmw  = (cmd_q.op != OP_WRITE) && (cmd_q.op != OP_READ);
    assign modify_data = (cmd_q.op == OP_SET) ? (rdata_q | cmd_q.data)
                                              : (rdata_q & ~cmd_q.data);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                state_d = cmd_is_rmw ? StModify : StResp;
            end
            StModify: begin
                state_d = StResp;
            end
            StResp: begin
                // Chain straight into the next access to sustain throughput.
                if (rsp_ready_i) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = StAccess;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cmd_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                cmd_q <= fifo_mem[rd_ptr_q];
            end
            // WRITE reports 0; every other op reports the value read in ACCESS.
            if (state_q == StAccess) begin
                rdata_q <= (cmd_q.op == OP_WRITE) ? '0 : bus_rdata_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state and cmd_q only
    // ------------------------------------------------------------------
    always_comb begin
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        bus_we_o    = 1'b0;
        bus_re_o    = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_data_o  = '0;
        case (state_q)
            StAccess: begin
                bus_addr_o = cmd_q.addr;
                if (cmd_q.op == OP_WRITE) begin
                    bus_we_o    = 1'b1;
                    bus_wdata_o = cmd_q.data;
                end else begin
                    bus_re_o = 1'b1;
                end
            end
            StModify: begin
                bus_addr_o  = cmd_q.addr;
                bus_we_o    = 1'b1;
                bus_wdata_o = modify_data;
            end
            StResp: begin
                rsp_valid_o = 1'b1;
                rsp_data_o  = rdata_q;
            end
            default: ;
        endcase
    end

    assign busy_o = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_reg_master.sv
// tb_reg_master: self-checking bench for reg_master with a small gpio-like
// slave model (four 32-bit registers at 0x0, 0x4, 0x8, 0xC) and a response
// scoreboard fed with expected values when commands are issued.
module tb_reg_master;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_we;
    logic              bus_re;
    logic [DATA_W-1:0] bus_rdata;
    logic              busy;

    reg_master #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .bus_addr_o  (bus_addr),
        .bus_wdata_o (bus_wdata),
        .bus_we_o    (bus_we),
        .bus_re_o    (bus_re),
        .bus_rdata_i (bus_rdata),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int rsp_cnt = 0;
    logic [31:0] last_we_data = '0;
    logic [31:0] last_re_addr = '0;
    logic [31:0] exp_q [$];

    // Slave model
    logic [31:0] regs [4] = '{default: 32'h0};
    logic        rand_mode = 1'b0;
    logic [31:0] rand_val  = '0;

    assign bus_rdata = rand_mode ? rand_val : regs[bus_addr[3:2]];

    always @(posedge clk) begin
        if (bus_we) regs[bus_addr[3:2]] <= bus_wdata;
    end

    // Random read data: a fresh value is driven each cycle; the value seen in
    // an re cycle becomes the expected response.
    always @(negedge clk) begin
        if (rand_mode) begin : gen_rand
            logic [31:0] r;
            r = $urandom;
            rand_val <= r;
            if (bus_re) exp_q.push_back(r);
        end
    end

    // Bus monitor
    always @(negedge clk) begin
        if (bus_we && bus_re) begin
            checks++;
            errors++;
            $display("FAIL bus_excl we and re both high at %0t", $time);
        end
        if (bus_we) begin
            we_cnt++;
            last_we_data = bus_wdata;
        end
        if (bus_re) begin
            re_cnt++;
            last_re_addr = bus_addr;
        end
    end

    // Response scoreboard
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            logic [31:0] e;
            rsp_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got %h want none", rsp_data);
            end else begin
                e = exp_q.pop_front();
                if (rsp_data !== e) begin
                    errors++;
                    $display("FAIL rsp_data got %h want %h", rsp_data, e);
                end
            end
        end
    end

    // Drive one command and return #1 after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] e, input bit push_exp);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        if (push_exp) exp_q.push_back(e);
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got ready=0 want ready=1");
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || rsp_valid) && n < 200);
        checks++;
        if (busy || rsp_valid) begin
            errors++;
            $display("FAIL idle_timeout got busy=%0b want 0", busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, busy, bus_we, bus_re} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 10000",
                     {req_ready, rsp_valid, busy, bus_we, bus_re});
        end
        checks++;
        if ({bus_addr, bus_wdata, rsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h want 0", bus_addr, bus_wdata, rsp_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_write();
        int we0 = we_cnt;
        int re0 = re_cnt;
        rsp_ready = 1'b1;
        send(OP_WR, 32'h0, 32'hA5, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if ({rsp_valid, bus_we} !== 2'b00) begin
            errors++;
            $display("FAIL wr_edge1 got %b want 00", {rsp_valid, bus_we});
        end
        @(negedge clk);
        checks++;
        if ({bus_we, bus_re, rsp_valid} !== 3'b100 || bus_addr !== 32'h0
            || bus_wdata !== 32'hA5) begin
            errors++;
            $display("FAIL wr_access got we/re/v=%b addr=%h wdata=%h want 100 0 a5",
                     {bus_we, bus_re, rsp_valid}, bus_addr, bus_wdata);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || bus_wdata !== 32'h0) begin
            errors++;
            $display("FAIL wr_latency got rsp_valid=%b wdata=%h want 1 0", rsp_valid, bus_wdata);
        end
        wait_idle();
        checks++;
        if (regs[0] !== 32'hA5 || we_cnt - we0 != 1 || re_cnt - re0 != 0) begin
            errors++;
            $display("FAIL wr_slave got reg=%h we=%0d re=%0d want a5 1 0",
                     regs[0], we_cnt - we0, re_cnt - re0);
        end
    endtask

    task automatic test_read();
        int we0;
        int re0;
        send(OP_WR, 32'h4, 32'h0F, 32'h0, 1'b1);
        wait_idle();
        we0 = we_cnt;
        re0 = re_cnt;
        send(OP_RD, 32'h4, 32'h0, 32'h0000000F, 1'b1);
        wait_idle();
        checks++;
        if (re_cnt - re0 != 1 || we_cnt - we0 != 0 || last_re_addr !== 32'h4) begin
            errors++;
            $display("FAIL rd_strobes got re=%0d we=%0d addr=%h want 1 0 4",
                     re_cnt - re0, we_cnt - we0, last_re_addr);
        end
    endtask

    task automatic test_set_clear();
        send(OP_SET, 32'h0, 32'h10, 32'hA5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus_re, bus_we} !== 2'b10 || bus_addr !== 32'h0) begin
            errors++;
            $display("FAIL set_read got re/we=%b addr=%h want 10 0", {bus_re, bus_we}, bus_addr);
        end
        @(negedge clk);
        checks++;
        if ({bus_re, bus_we, rsp_valid} !== 3'b010 || bus_wdata !== 32'hB5) begin
            errors++;
            $display("FAIL set_modify got re/we/v=%b wdata=%h want 010 b5",
                     {bus_re, bus_we, rsp_valid}, bus_wdata);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL set_latency got rsp_valid=%b want 1", rsp_valid);
        end
        wait_idle();
        send(OP_CLR, 32'h0, 32'h05, 32'hB5, 1'b1);
        wait_idle();
        checks++;
        if (last_we_data !== 32'hB0 || regs[0] !== 32'hB0) begin
            errors++;
            $display("FAIL clr_wdata got %h reg=%h want b0", last_we_data, regs[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] addrs [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0};
        logic [31:0] vals  [5] = '{32'hB0, 32'h0F, 32'h11111111, 32'h22222222, 32'hB0};
        int hs = 0;
        int prev = -1;
        send(OP_WR, 32'h8, 32'h11111111, 32'h0, 1'b1);
        send(OP_WR, 32'hC, 32'h22222222, 32'h0, 1'b1);
        wait_idle();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(OP_RD, addrs[i], 32'h0, vals[i], 1'b1);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got req_ready=%b want 0", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = OP_WR;
        req_addr  = 32'h0;
        req_data  = 32'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 32'hB0) begin
                errors++;
                $display("FAIL bp_stall got ready=%b valid=%b data=%h want 0 1 b0",
                         req_ready, rsp_valid, rsp_data);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                if (prev >= 0) begin
                    checks++;
                    if (c - prev != 2) begin
                        errors++;
                        $display("FAIL bp_cadence got %0d want 2", c - prev);
                    end
                end
                prev = c;
                hs++;
            end
        end
        checks++;
        if (hs != 5) begin
            errors++;
            $display("FAIL bp_count got %0d want 5", hs);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int r0;
        send(OP_SET, 32'h0, 32'h01, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus_we !== 1'b1) begin
            errors++;
            $display("FAIL rm_modify got we=%b want 1", bus_we);
        end
        r0 = rsp_cnt;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus_we, bus_re, rsp_valid, busy, req_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL rm_abort got %b want 00001",
                     {bus_we, bus_re, rsp_valid, busy, req_ready});
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (regs[0] !== 32'hB0) begin
            errors++;
            $display("FAIL rm_unmodified got %h want b0", regs[0]);
        end
        send(OP_RD, 32'h0, 32'h0, 32'hB0, 1'b1);
        wait_idle();
        checks++;
        if (rsp_cnt - r0 != 1) begin
            errors++;
            $display("FAIL rm_rsp_count got %0d want 1", rsp_cnt - r0);
        end
    endtask

    task automatic test_back_to_back();
        int we0 = we_cnt;
        int r0  = rsp_cnt;
        rsp_ready = 1'b1;
        rand_mode = 1'b1;
        for (int i = 0; i < 8; i++) send(OP_RD, 32'(i % 4) << 2, 32'h0, 32'h0, 1'b0);
        wait_idle();
        rand_mode = 1'b0;
        checks++;
        if (we_cnt - we0 != 0 || rsp_cnt - r0 != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_summary got we=%0d rsp=%0d left=%0d want 0 8 0",
                     we_cnt - we0, rsp_cnt - r0, exp_q.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_addr  = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_set_clear();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
